// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory / stack port.
// Holds default widths, the stack-pointer reset value, the read FSM state
// encoding and the stack step direction constants.
package dmem_pkg;

  localparam int unsigned AddrWidth = 8;
  localparam int unsigned DataWidth = 16;
  localparam logic [7:0]  SpInit    = 8'hFF;

  // Read FSM encoding, kept as plain constants for legacy compatibility.
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StResp = 1'b1;

  // Value of sp_dec selecting each step direction.
  localparam logic SpDirInc = 1'b0;
  localparam logic SpDirDec = 1'b1;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with saturating step and sticky overflow/underflow flags.
// Ports:
//   clk, reset_cycle   clock and asynchronous active-high reset
//   sp_en, sp_dec      step enable and direction (1 = decrement)
//   sp                 current stack pointer
//   stack_ovf          sticky: decrement attempted at sp == 0
//   stack_unf          sticky: increment attempted at sp == SP_INIT
module stack_pointer
  import dmem_pkg::*;
#(
  parameter int unsigned        ADDR_W  = AddrWidth,
  parameter logic [ADDR_W-1:0]  SP_INIT = SpInit
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic              sp_en,
  input  logic              sp_dec,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam logic [ADDR_W-1:0] One = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  // Out-of-range steps leave sp unchanged and latch the matching flag.
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (sp_en) begin
      if (sp_dec == SpDirDec) begin
        if (sp_q == '0) ovf_d = 1'b1;
        else            sp_d  = sp_q - One;
      end else begin
        if (sp_q == SP_INIT) unf_d = 1'b1;
        else                 sp_d  = sp_q + One;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      sp_q  <= SP_INIT;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: rtl/data_mem_port.sv
// Responder for the control unit's data-memory / stack strobes.
// Holds D_MAR, the data RAM and the read-response FSM; the stack pointer
// lives in stack_pointer.
// Ports:
//   clk, reset_cycle      clock and asynchronous active-high reset
//   dmar_in, ld_mar       direct address and D_MAR load strobe
//   sp_sel                D_MAR source is SP instead of dmar_in
//   sp_en, sp_dec         stack pointer step and direction
//   rd, wr, wdata         read / write strobes and write data
//   rdata, rvalid         registered read data and its one-cycle valid pulse
//   sp, stack_ovf/unf     stack pointer and sticky range-error flags
module data_mem_port
  import dmem_pkg::*;
#(
  parameter int unsigned        ADDR_W  = AddrWidth,
  parameter int unsigned        DATA_W  = DataWidth,
  parameter logic [ADDR_W-1:0]  SP_INIT = SpInit
) (
  input  logic              clk,
  input  logic              reset_cycle,
  input  logic [ADDR_W-1:0] dmar_in,
  input  logic              ld_mar,
  input  logic              sp_sel,
  input  logic              sp_en,
  input  logic              sp_dec,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] mar_src;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;
  logic [0:0]        state_q, state_d;
  logic              rd_ok;

  stack_pointer #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_stack_pointer (
    .clk         (clk),
    .reset_cycle (reset_cycle),
    .sp_en       (sp_en),
    .sp_dec      (sp_dec),
    .sp          (sp),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  // sp here is the pre-step value, so a push writes the current free slot.
  assign mar_src = sp_sel ? sp : dmar_in;
  // A load in the same cycle as the access bypasses the register.
  assign ea      = ld_mar ? mar_src : mar_q;
  // A simultaneous write wins; the read is dropped.
  assign rd_ok   = rd & ~wr;

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) mar_q <= '0;
    else if (ld_mar) mar_q <= mar_src;
  end

  // RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr) mem_q[ea] <= wdata;
  end

  always_comb begin
    state_d = StIdle;
    if (rd_ok) state_d = StResp;
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_ok) rdata_q <= mem_q[ea];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = (state_q == StResp);

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

  logic        clk = 1'b0;
  logic        reset_cycle;
  logic [7:0]  dmar_in;
  logic        ld_mar, sp_sel, sp_en, sp_dec, rd, wr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic [7:0]  sp;
  logic        stack_ovf, stack_unf;

  data_mem_port dut (
    .clk         (clk),
    .reset_cycle (reset_cycle),
    .dmar_in     (dmar_in),
    .ld_mar      (ld_mar),
    .sp_sel      (sp_sel),
    .sp_en       (sp_en),
    .sp_dec      (sp_dec),
    .rd          (rd),
    .wr          (wr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .sp          (sp),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_mem [256];
  logic [7:0]  m_mar;
  logic [7:0]  m_sp;
  logic        m_ovf, m_unf;
  logic [15:0] exp_q[$];
  logic        rv_exp;
  logic        mon_en;

  // Response monitor: every cycle rvalid must match the expectation,
  // and each expected response is popped from the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rvalid", {31'd0, rvalid}, {31'd0, rv_exp});
      if (rv_exp) begin
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("rdata", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic model_reset();
    m_mar  = 8'h00;
    m_sp   = 8'hFF;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    rv_exp = 1'b0;
    exp_q.delete();
  endtask

  // Drive one cycle of strobes, update the model, advance one clock.
  task automatic drive(input logic l, input logic s, input logic [7:0] a, input logic e,
                       input logic dc, input logic r, input logic w, input logic [15:0] d);
    logic [7:0] ea;
    ld_mar = l; sp_sel = s; dmar_in = a; sp_en = e; sp_dec = dc;
    rd = r; wr = w; wdata = d;
    ea = l ? (s ? m_sp : a) : m_mar;
    if (r && !w) exp_q.push_back(m_mem[ea]);
    if (w) m_mem[ea] = d;
    if (l) m_mar = s ? m_sp : a;
    if (e) begin
      if (dc) begin
        if (m_sp == 8'h00) m_ovf = 1'b1;
        else m_sp = m_sp - 8'd1;
      end else begin
        if (m_sp == 8'hFF) m_unf = 1'b1;
        else m_sp = m_sp + 8'd1;
      end
    end
    @(posedge clk);
    rv_exp = r & ~w;
    #1;
    ld_mar = 0; sp_sel = 0; dmar_in = 0; sp_en = 0; sp_dec = 0; rd = 0; wr = 0; wdata = 0;
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 0, 0, 0, 0, 16'h0000);
  endtask

  task automatic check_stack(input string tag);
    check({tag, "_sp"},  {24'd0, sp},        {24'd0, m_sp});
    check({tag, "_ovf"}, {31'd0, stack_ovf}, {31'd0, m_ovf});
    check({tag, "_unf"}, {31'd0, stack_unf}, {31'd0, m_unf});
  endtask

  task automatic do_reset();
    mon_en = 0;
    reset_cycle = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_cycle = 0;
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata",  {16'd0, rdata},  32'd0);
    check_stack("rst");
    mon_en = 1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    ld_mar = 0; sp_sel = 0; dmar_in = 0; sp_en = 0; sp_dec = 0; rd = 0; wr = 0; wdata = 0;
    mon_en = 0;
    do_reset();

    // Direct write then read, then idle to confirm single-cycle rvalid
    drive(1, 0, 8'h12, 0, 0, 0, 1, 16'hBEEF);
    drive(1, 0, 8'h12, 0, 0, 1, 0, 16'h0000);
    idle();
    idle();

    // Read through MAR without reloading it
    drive(1, 0, 8'h20, 0, 0, 0, 1, 16'h5A5A);
    drive(0, 0, 8'h00, 0, 0, 1, 0, 16'h0000);
    idle();

    // Push / pop round trip
    drive(1, 1, 8'h00, 0, 0, 0, 1, 16'h00A5);
    drive(0, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
    check_stack("push");
    drive(0, 0, 8'h00, 1, 0, 0, 0, 16'h0000);
    check_stack("pop");
    drive(1, 1, 8'h00, 0, 0, 1, 0, 16'h0000);
    idle();

    // Underflow, then pushes must not clear the flag
    drive(0, 0, 8'h00, 1, 0, 0, 0, 16'h0000);
    check_stack("unf");
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 8'h00, 0, 0, 0, 1, 16'h0100 + 16'(i));
      drive(0, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
    end
    check_stack("unf_sticky");
    // Pop both values back in LIFO order
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 8'h00, 1, 0, 0, 0, 16'h0000);
      drive(1, 1, 8'h00, 0, 0, 1, 0, 16'h0000);
    end
    idle();

    // Collision: write wins, read dropped
    drive(1, 0, 8'h30, 0, 0, 1, 1, 16'h1234);
    drive(1, 0, 8'h30, 0, 0, 1, 0, 16'h0000);
    idle();

    // Back-to-back reads
    drive(1, 0, 8'h40, 0, 0, 0, 1, 16'hC0DE);
    drive(1, 0, 8'h41, 0, 0, 0, 1, 16'hF00D);
    drive(1, 0, 8'h40, 0, 0, 1, 0, 16'h0000);
    drive(1, 0, 8'h41, 0, 0, 1, 0, 16'h0000);
    drive(1, 0, 8'h12, 0, 0, 1, 0, 16'h0000);
    idle();

    // Overflow: walk SP down to 0, then one more decrement
    while (m_sp != 8'h00) drive(0, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
    check_stack("at_zero");
    drive(0, 0, 8'h00, 1, 1, 0, 0, 16'h0000);
    check_stack("ovf");
    idle();
    check_stack("ovf_sticky");

    // Asynchronous reset while a response is being presented
    drive(1, 0, 8'h30, 0, 0, 1, 0, 16'h0000);
    mon_en = 0;
    check("resp_rvalid", {31'd0, rvalid}, 32'd1);
    check("resp_rdata",  {16'd0, rdata},  32'h1234);
    #2;
    reset_cycle = 1;
    #1;
    check("async_rvalid", {31'd0, rvalid}, 32'd0);
    check("async_rdata",  {16'd0, rdata},  32'd0);
    check("async_sp",     {24'd0, sp},     32'hFF);
    check("async_ovf",    {31'd0, stack_ovf}, 32'd0);
    do_reset();
    idle();

    // RAM survives reset
    drive(1, 0, 8'h40, 0, 0, 1, 0, 16'h0000);
    idle();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_port.md
# data_mem_port

Responder side of the data-memory/stack strobe interface driven by the CPU control unit. Holds the data memory address register (D_MAR), the stack pointer, and the data RAM. Services read, write, push and pop strobes with fixed single-cycle timing. Sits between the control unit, the register file / ALU data bus and the PC return path.

## Interface
- ADDR_W, 8, data address width (DMAR_bus width)
- DATA_W, 16, data word width
- SP_INIT, 8'hFF, stack pointer reset value and empty-stack top
- clk  input  1  clock, rising edge
- reset_cycle  input  1  reset, asynchronous, active-high
- dmar_in  input  ADDR_W  direct address from control unit
- ld_mar  input  1  load D_MAR this cycle
- sp_sel  input  1  D_MAR source is SP instead of dmar_in
- sp_en  input  1  step stack pointer
- sp_dec  input  1  with sp_en: 1 = decrement, 0 = increment
- rd  input  1  read strobe
- wr  input  1  write strobe
- wdata  input  DATA_W  write data (register or PC)
- rdata  output  DATA_W  registered read data
- rvalid  output  1  one-cycle pulse, rdata updated
- sp  output  ADDR_W  current stack pointer
- stack_ovf  output  1  sticky, decrement attempted at sp==0
- stack_unf  output  1  sticky, increment attempted at sp==SP_INIT

## Operation
- Effective address: ea = ld_mar ? (sp_sel ? sp : dmar_in) : mar. Address load and access in the same cycle use the new address.
- ld_mar: mar <= (sp_sel ? sp : dmar_in).
- wr: mem[ea] <= wdata on the rising edge.
- rd without wr: rdata <= mem[ea], rvalid <= 1 for the next cycle. Otherwise rvalid <= 0 and rdata holds.
- rd and wr in the same cycle: the write is performed, the read is dropped, and rvalid stays 0.
- Stack convention: SP points to the next free slot and the stack grows downward.
  - Push: write at SP with sp_sel, then sp_en&sp_dec.
  - Pop: sp_en&~sp_dec, then read at SP with sp_sel.
- Decrement at sp==0: sp holds and stack_ovf is set.
- Increment at sp==SP_INIT: sp holds and stack_unf is set.
- Flags clear only on reset.
- SP step and an SP-sourced address in the same cycle use the pre-step SP.
- Internal read FSM: IDLE -> RESP on an accepted rd, RESP -> RESP on back-to-back rd, RESP -> IDLE otherwise. rvalid = (state==RESP).

## Timing
- Reset values:
  - sp = SP_INIT, mar = 0, rdata = 0, rvalid = 0, stack_ovf = 0, stack_unf = 0, FSM = IDLE.
  - RAM contents are not cleared.
- Write latency is 0: the data is visible to a read in the next cycle.
- Read latency is 1: rdata and rvalid are valid in the cycle after rd. Back-to-back reads are allowed, one per cycle.
- Reset asserted mid-read: rvalid drops immediately and the pending read is lost.
- SP update is visible on the sp output in the cycle after sp_en.

## Structure
- Shared package dmem_pkg holds:
  - the ADDR_W / DATA_W / SP_INIT defaults
  - the FSM state encoding (IDLE, RESP)
  - the stack-direction constants
- One sub-module, stack_pointer: SP register, saturating step, ovf/unf sticky flags.
- RAM, MAR and read FSM live in data_mem_port.

## Test plan
- Reset, then observe outputs: sp=8'hFF, rvalid=0, rdata=0, both flags 0.
- Direct write then read:
  - ld_mar, dmar_in=8'h12, wr, wdata=16'hBEEF.
  - Next cycle: ld_mar, dmar_in=8'h12, rd.
  - Required: one cycle later rdata=16'hBEEF, rvalid=1 for exactly one cycle.
- Push/pop round trip:
  - Write 16'h00A5 with sp_sel at SP=FF, then decrement; sp=FE.
  - Increment (sp=FF), then read with sp_sel.
  - Required: rdata=16'h00A5.
- Underflow: increment at sp=FF -> sp stays FF, stack_unf=1 and stays 1 through later pushes.
- Overflow: 255 decrements, then one more at sp=0 -> sp stays 0, stack_ovf=1.
- Collision: rd&wr to 8'h30 with wdata=16'h1234 -> rvalid=0; a following read of 8'h30 returns 16'h1234. Async reset during RESP clears rvalid in the same cycle.
